// File: rtl/spi_xfer_seq.sv
// Transaction sequencer for a register-mapped SPI core: runs the configure/select/byte/deselect
// write sequence for a command, streaming TX bytes from one FIFO and captured RX bytes into another.
module spi_xfer_seq #(
    parameter int S     = 2,
    parameter int DEPTH = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [7:0]        cmd_len,
    input  logic [S-1:0]      cmd_ss,
    input  logic [15:0]       cmd_dvsr,
    input  logic              cmd_cpol,
    input  logic              cmd_cpha,
    input  logic              tx_valid,
    output logic              tx_ready,
    input  logic [7:0]        tx_data,
    output logic              rx_valid,
    input  logic              rx_ready,
    output logic [7:0]        rx_data,
    output logic              busy,
    output logic              done,
    output logic              core_write,
    output logic [1:0]        core_instr,
    output logic [31:0]       core_wr_data,
    input  logic [31:0]       core_rd_data
);

    localparam int AW = $clog2(DEPTH);

    typedef enum logic [3:0] {
        IDLE, CFG, SEL, LOAD, START, WBUSY, WDONE, CAP, DESEL, FIN
    } state_t;

    state_t state, next;

    logic [7:0]   remaining;
    logic [S-1:0] ss_q;
    logic [15:0]  dvsr_q;
    logic         cpol_q, cpha_q;

    logic [7:0]   tx_mem [DEPTH];
    logic [7:0]   rx_mem [DEPTH];
    logic [AW:0]  tx_wr, tx_rd, rx_wr, rx_rd;
    logic         tx_full, tx_empty, rx_full, rx_empty;
    logic         tx_push, tx_pop, rx_push, rx_pop, accept;

    logic         core_rdy;
    logic         unused_rd;

    assign core_rdy  = core_rd_data[8];
    assign unused_rd = ^core_rd_data[31:9];

    // Full when the pointers differ only in the wrap bit; empty when identical.
    assign tx_full  = (tx_wr[AW] != tx_rd[AW]) && (tx_wr[AW-1:0] == tx_rd[AW-1:0]);
    assign tx_empty = (tx_wr == tx_rd);
    assign rx_full  = (rx_wr[AW] != rx_rd[AW]) && (rx_wr[AW-1:0] == rx_rd[AW-1:0]);
    assign rx_empty = (rx_wr == rx_rd);

    assign tx_ready  = !tx_full;
    assign rx_valid  = !rx_empty;
    assign rx_data   = rx_mem[rx_rd[AW-1:0]];
    assign tx_push   = tx_valid && !tx_full;
    assign rx_pop    = rx_ready && !rx_empty;
    assign cmd_ready = (state == IDLE);
    assign busy      = (state != IDLE);
    assign accept    = cmd_valid && cmd_ready;

    always_ff @(posedge clk) begin
        if (tx_push) tx_mem[tx_wr[AW-1:0]] <= tx_data;
        if (rx_push) rx_mem[rx_wr[AW-1:0]] <= core_rd_data[7:0];
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tx_wr <= '0;
            tx_rd <= '0;
            rx_wr <= '0;
            rx_rd <= '0;
        end else begin
            if (tx_push)             tx_wr <= tx_wr + 1'b1;
            if (tx_pop && !tx_empty) tx_rd <= tx_rd + 1'b1;
            if (rx_push)             rx_wr <= rx_wr + 1'b1;
            if (rx_pop)              rx_rd <= rx_rd + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            remaining <= '0;
            ss_q      <= '0;
            dvsr_q    <= '0;
            cpol_q    <= 1'b0;
            cpha_q    <= 1'b0;
        end else begin
            state <= next;
            if (accept) begin
                remaining <= cmd_len;
                ss_q      <= cmd_ss;
                dvsr_q    <= cmd_dvsr;
                cpol_q    <= cmd_cpol;
                cpha_q    <= cmd_cpha;
            end else if (rx_push) begin
                remaining <= remaining - 8'd1;
            end
        end
    end

    always_comb begin
        next         = state;
        core_write   = 1'b0;
        core_instr   = 2'b00;
        core_wr_data = 32'h0;
        done         = 1'b0;
        tx_pop       = 1'b0;
        rx_push      = 1'b0;
        case (state)
            IDLE:  if (cmd_valid) next = (cmd_len == 8'd0) ? FIN : CFG;
            CFG: begin
                core_write   = 1'b1;
                core_instr   = 2'b11;
                core_wr_data = {14'b0, cpha_q, cpol_q, dvsr_q};
                next         = SEL;
            end
            SEL: begin
                core_write   = 1'b1;
                core_instr   = 2'b01;
                core_wr_data = {{(32-S){1'b1}}, ss_q};
                next         = LOAD;
            end
            LOAD:  if (!tx_empty && core_rdy) next = START;
            START: begin
                core_write   = 1'b1;
                core_instr   = 2'b10;
                core_wr_data = {24'b0, tx_mem[tx_rd[AW-1:0]]};
                tx_pop       = 1'b1;
                next         = WBUSY;
            end
            WBUSY: if (!core_rdy) next = WDONE;
            WDONE: if (core_rdy) next = CAP;
            // A full RX FIFO holds the captured byte in the core until space frees up.
            CAP: if (!rx_full) begin
                rx_push = 1'b1;
                next    = (remaining == 8'd1) ? DESEL : LOAD;
            end
            DESEL: begin
                core_write   = 1'b1;
                core_instr   = 2'b01;
                core_wr_data = 32'hFFFF_FFFF;
                next         = FIN;
            end
            FIN: begin
                done = 1'b1;
                next = IDLE;
            end
            default: next = IDLE;
        endcase
    end

endmodule

// File: tb/tb_spi_xfer_seq.sv
// Directed self-checking bench for spi_xfer_seq with a behavioural SPI core model
// that goes busy for a few cycles after each data write and returns tx ^ echo_xor.
module tb_spi_xfer_seq;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        cmd_valid = 1'b0, cmd_ready;
    logic [7:0]  cmd_len = '0;
    logic [1:0]  cmd_ss = '0;
    logic [15:0] cmd_dvsr = '0;
    logic        cmd_cpol = 1'b0, cmd_cpha = 1'b0;
    logic        tx_valid = 1'b0, tx_ready;
    logic [7:0]  tx_data = '0;
    logic        rx_valid, rx_ready = 1'b0;
    logic [7:0]  rx_data;
    logic        busy, done, core_write;
    logic [1:0]  core_instr;
    logic [31:0] core_wr_data, core_rd_data;

    int n_cmp = 0;
    int n_fail = 0;

    logic [7:0]  echo_xor = 8'h00;
    logic [3:0]  core_cnt;
    logic [7:0]  core_rx;
    logic [1:0]  log_instr [256];
    logic [31:0] log_data [256];
    int          log_n = 0;
    int          done_cnt = 0;

    spi_xfer_seq #(.S(2), .DEPTH(8)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_len(cmd_len), .cmd_ss(cmd_ss),
        .cmd_dvsr(cmd_dvsr), .cmd_cpol(cmd_cpol), .cmd_cpha(cmd_cpha),
        .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_data(tx_data),
        .rx_valid(rx_valid), .rx_ready(rx_ready), .rx_data(rx_data),
        .busy(busy), .done(done), .core_write(core_write), .core_instr(core_instr),
        .core_wr_data(core_wr_data), .core_rd_data(core_rd_data)
    );

    always #5 clk = ~clk;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            core_cnt <= '0;
            core_rx  <= '0;
        end else if (core_write && core_instr == 2'b10) begin
            core_cnt <= 4'd5;
            core_rx  <= core_wr_data[7:0] ^ echo_xor;
        end else if (core_cnt != 0) begin
            core_cnt <= core_cnt - 4'd1;
        end
    end
    assign core_rd_data = {23'b0, core_cnt == 4'd0, core_rx};

    always @(posedge clk) begin
        if (core_write) begin
            log_instr[log_n[7:0]] <= core_instr;
            log_data[log_n[7:0]]  <= core_wr_data;
            log_n <= log_n + 1;
        end
        if (done) done_cnt <= done_cnt + 1;
    end

    function automatic int data_writes(input int from);
        int c = 0;
        for (int i = from; i < log_n; i++) if (log_instr[i[7:0]] == 2'b10) c++;
        return c;
    endfunction

    task automatic push_tx(input logic [7:0] d);
        int t = 0;
        @(negedge clk);
        while (!tx_ready && t < 300) begin @(negedge clk); t++; end
        tx_valid = 1'b1; tx_data = d;
        @(negedge clk);
        tx_valid = 1'b0;
    endtask

    task automatic send_cmd(input logic [7:0] len, input logic [1:0] ss, input logic [15:0] dvsr,
                            input logic cpol, input logic cpha);
        int t = 0;
        @(negedge clk);
        cmd_len = len; cmd_ss = ss; cmd_dvsr = dvsr; cmd_cpol = cpol; cmd_cpha = cpha;
        cmd_valid = 1'b1;
        while (!cmd_ready && t < 300) begin @(negedge clk); t++; end
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic wait_done(input int base, output int drops);
        int t = 0;
        drops = 0;
        forever begin
            @(negedge clk);
            if (done_cnt > base || t > 2000) break;
            if (!busy) drops++;
            t++;
        end
        n_cmp++;
        if (done_cnt <= base) begin n_fail++; $display("FAIL done_timeout: got %0d pulses want >=1", done_cnt - base); end
    endtask

    task automatic pop_check(input string name, input logic [7:0] exp);
        int t = 0;
        while (!rx_valid && t < 300) begin @(negedge clk); t++; end
        n_cmp++;
        if (rx_valid !== 1'b1 || rx_data !== exp) begin
            n_fail++; $display("FAIL %s: got valid=%b data=%h want data=%h", name, rx_valid, rx_data, exp);
        end
        rx_ready = 1'b1;
        @(negedge clk);
        rx_ready = 1'b0;
    endtask

    task automatic test_reset;
        #12;
        n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy: got %b want 0", busy); end
        n_cmp++; if (done !== 1'b0) begin n_fail++; $display("FAIL rst_done: got %b want 0", done); end
        n_cmp++; if (core_write !== 1'b0 || core_instr !== 2'b00 || core_wr_data !== 32'h0) begin
            n_fail++; $display("FAIL rst_core: got %b/%b/%h want 0/00/0", core_write, core_instr, core_wr_data); end
        n_cmp++; if (tx_ready !== 1'b1 || rx_valid !== 1'b0) begin
            n_fail++; $display("FAIL rst_fifo: got tx_ready=%b rx_valid=%b want 1/0", tx_ready, rx_valid); end
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        n_cmp++; if (cmd_ready !== 1'b1) begin n_fail++; $display("FAIL rst_cmd_ready: got %b want 1", cmd_ready); end
    endtask

    task automatic test_single_byte;
        int base = log_n;
        int dbase = done_cnt;
        int drops;
        echo_xor = 8'h99;
        push_tx(8'hA5);
        send_cmd(8'd1, 2'b10, 16'd4, 1'b0, 1'b0);
        wait_done(dbase, drops);
        repeat (3) @(negedge clk);
        n_cmp++; if (log_n - base !== 4) begin n_fail++; $display("FAIL single_nwrites: got %0d want 4", log_n - base); end
        n_cmp++; if (log_instr[base] !== 2'b11 || log_data[base] !== 32'h0000_0004) begin
            n_fail++; $display("FAIL single_cfg: got %b/%h want 11/00000004", log_instr[base], log_data[base]); end
        n_cmp++; if (log_instr[base+1] !== 2'b01 || log_data[base+1] !== 32'hFFFF_FFFE) begin
            n_fail++; $display("FAIL single_sel: got %b/%h want 01/fffffffe", log_instr[base+1], log_data[base+1]); end
        n_cmp++; if (log_instr[base+2] !== 2'b10 || log_data[base+2] !== 32'h0000_00A5) begin
            n_fail++; $display("FAIL single_data: got %b/%h want 10/000000a5", log_instr[base+2], log_data[base+2]); end
        n_cmp++; if (log_instr[base+3] !== 2'b01 || log_data[base+3] !== 32'hFFFF_FFFF) begin
            n_fail++; $display("FAIL single_desel: got %b/%h want 01/ffffffff", log_instr[base+3], log_data[base+3]); end
        n_cmp++; if (done_cnt - dbase !== 1) begin n_fail++; $display("FAIL single_done_count: got %0d want 1", done_cnt - dbase); end
        pop_check("single_rx", 8'h3C);
        n_cmp++; if (rx_valid !== 1'b0) begin n_fail++; $display("FAIL single_rx_empty: got %b want 0", rx_valid); end
    endtask

    task automatic test_burst;
        int base = log_n;
        int dbase = done_cnt;
        int drops;
        echo_xor = 8'h80;
        for (int i = 1; i <= 4; i++) push_tx(8'(i));
        send_cmd(8'd4, 2'b01, 16'd2, 1'b1, 1'b1);
        wait_done(dbase, drops);
        n_cmp++; if (drops !== 0) begin n_fail++; $display("FAIL burst_busy: got %0d idle cycles want 0", drops); end
        n_cmp++; if (log_data[base] !== 32'h0003_0002 || log_data[base+1] !== 32'hFFFF_FFFD) begin
            n_fail++; $display("FAIL burst_cfg_sel: got %h/%h want 00030002/fffffffd", log_data[base], log_data[base+1]); end
        for (int i = 0; i < 4; i++) begin
            n_cmp++;
            if (log_instr[base+2+i] !== 2'b10 || log_data[base+2+i] !== 32'(i + 1)) begin
                n_fail++; $display("FAIL burst_data%0d: got %b/%h want 10/%h", i, log_instr[base+2+i], log_data[base+2+i], 32'(i + 1));
            end
        end
        for (int i = 0; i < 4; i++) pop_check("burst_rx", 8'(i + 1) ^ 8'h80);
    endtask

    task automatic test_back_pressure;
        int base = log_n;
        int dbase = done_cnt;
        int drops;
        echo_xor = 8'h00;
        rx_ready = 1'b0;
        for (int i = 0; i < 8; i++) push_tx(8'h10 + 8'(i));
        send_cmd(8'd10, 2'b10, 16'd1, 1'b0, 1'b1);
        push_tx(8'h18);
        push_tx(8'h19);
        repeat (200) @(negedge clk);
        n_cmp++; if (done_cnt !== dbase || busy !== 1'b1 || core_write !== 1'b0) begin
            n_fail++; $display("FAIL bp_hold: got done=%0d busy=%b wr=%b want 0/1/0", done_cnt - dbase, busy, core_write); end
        n_cmp++; if (data_writes(base) !== 9) begin n_fail++; $display("FAIL bp_stall_writes: got %0d want 9", data_writes(base)); end
        for (int i = 0; i < 10; i++) pop_check("bp_rx", 8'h10 + 8'(i));
        wait_done(dbase, drops);
        n_cmp++; if (data_writes(base) !== 10) begin n_fail++; $display("FAIL bp_total_writes: got %0d want 10", data_writes(base)); end
    endtask

    task automatic test_starvation;
        int base = log_n;
        int dbase = done_cnt;
        int drops;
        echo_xor = 8'h0F;
        push_tx(8'h55);
        send_cmd(8'd2, 2'b10, 16'd8, 1'b0, 1'b0);
        repeat (50) @(negedge clk);
        n_cmp++; if (done_cnt !== dbase || busy !== 1'b1 || data_writes(base) !== 1) begin
            n_fail++; $display("FAIL starve_park: got done=%0d busy=%b writes=%0d want 0/1/1", done_cnt - dbase, busy, data_writes(base)); end
        push_tx(8'h66);
        wait_done(dbase, drops);
        n_cmp++; if (log_n - base !== 5) begin n_fail++; $display("FAIL starve_nwrites: got %0d want 5", log_n - base); end
        pop_check("starve_rx0", 8'h5A);
        pop_check("starve_rx1", 8'h69);
    endtask

    task automatic test_zero_len;
        int base = log_n;
        int dbase = done_cnt;
        int drops;
        send_cmd(8'd0, 2'b01, 16'd3, 1'b0, 1'b0);
        wait_done(dbase, drops);
        repeat (3) @(negedge clk);
        n_cmp++; if (log_n !== base) begin n_fail++; $display("FAIL zero_writes: got %0d want 0", log_n - base); end
        n_cmp++; if (done_cnt - dbase !== 1) begin n_fail++; $display("FAIL zero_done: got %0d want 1", done_cnt - dbase); end
    endtask

    task automatic test_reset_mid;
        int base;
        int dbase;
        int drops;
        int t = 0;
        echo_xor = 8'h00;
        push_tx(8'h77);
        push_tx(8'h88);
        base = log_n;
        send_cmd(8'd1, 2'b10, 16'd2, 1'b0, 1'b0);
        while (log_n < base + 3 && t < 300) begin @(negedge clk); t++; end
        @(negedge clk);
        #2 rst = 1'b0;
        #1;
        n_cmp++; if (busy !== 1'b0 || done !== 1'b0 || cmd_ready !== 1'b1) begin
            n_fail++; $display("FAIL midrst_ctl: got busy=%b done=%b cmd_ready=%b want 0/0/1", busy, done, cmd_ready); end
        n_cmp++; if (core_write !== 1'b0 || core_instr !== 2'b00 || core_wr_data !== 32'h0) begin
            n_fail++; $display("FAIL midrst_core: got %b/%b/%h want 0/00/0", core_write, core_instr, core_wr_data); end
        n_cmp++; if (tx_ready !== 1'b1 || rx_valid !== 1'b0) begin
            n_fail++; $display("FAIL midrst_fifo: got tx_ready=%b rx_valid=%b want 1/0", tx_ready, rx_valid); end
        @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        n_cmp++; if (log_n !== base + 3) begin n_fail++; $display("FAIL midrst_no_desel: got %0d writes want 3", log_n - base); end
        base = log_n;
        dbase = done_cnt;
        send_cmd(8'd1, 2'b01, 16'd2, 1'b0, 1'b0);
        repeat (20) @(negedge clk);
        n_cmp++; if (data_writes(base) !== 0 || busy !== 1'b1) begin
            n_fail++; $display("FAIL midrst_tx_empty: got writes=%0d busy=%b want 0/1", data_writes(base), busy); end
        push_tx(8'h42);
        wait_done(dbase, drops);
        pop_check("midrst_rx", 8'h42);
    endtask

    initial begin
        test_reset();
        test_single_byte();
        test_burst();
        test_back_pressure();
        test_starvation();
        test_zero_len();
        test_reset_mid();
        repeat (2) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no completion want $finish before 500000");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule

// File: doc/spi_xfer_seq.md
SPI_XFER_SEQ -- requirements
Module: spi_xfer_seq

Interface
REQ-001 SHALL have parameter S, default 2, number of active-low slave-select lines on the downstream SPI core.
REQ-002 SHALL have parameter DEPTH, default 8, entries in each of the TX and RX byte FIFOs (power of two).
REQ-003 SHALL have ports, clock and reset first:
- clk  in  1  single clock; all logic on its rising edge.
- rst  in  1  asynchronous, active-low reset.
- cmd_valid  in  1  transaction request.
- cmd_ready  out  1  high only in IDLE.
- cmd_len  in  8  byte count of the transaction.
- cmd_ss  in  S  active-low slave mask.
- cmd_dvsr  in  16  SCLK divisor.
- cmd_cpol, cmd_cpha  in  1 each  SPI mode.
- tx_valid / tx_ready / tx_data  in / out / in  1/1/8  TX byte stream into the TX FIFO.
- rx_valid / rx_ready / rx_data  out / in / out  1/1/8  RX byte stream out of the RX FIFO.
- busy  out  1  transaction in progress.
- done  out  1  one-cycle completion pulse.
- core_write  out  1  register write strobe to the SPI core.
- core_instr  out  2  register select: 01 slave select, 10 data/start, 11 control.
- core_wr_data  out  32  register write data.
- core_rd_data  in  32  [7:0] last received byte, [8] core ready.

Function
REQ-004 SHALL accept a command on a cycle with cmd_valid and cmd_ready both high, latching len, ss, dvsr, cpol and cpha.
REQ-005 SHALL implement the FSM IDLE -> CFG -> SEL -> LOAD -> START -> WBUSY -> WDONE -> CAP -> (LOAD if remaining > 0, else DESEL) -> IDLE.
REQ-006 In CFG, SHALL drive one cycle of core_write=1, core_instr=11, core_wr_data={14'b0, cpha, cpol, dvsr}.
REQ-007 In SEL, SHALL drive one cycle of core_write=1, core_instr=01, core_wr_data={(32-S)'b1, ss}.
REQ-008 LOAD SHALL wait until the TX FIFO is non-empty and core_rd_data[8]=1, then go to START.
REQ-009 In START, SHALL pop one TX byte and drive one cycle of core_write=1, core_instr=10, core_wr_data={24'b0, byte}.
REQ-010 WBUSY SHALL wait for core_rd_data[8]=0; WDONE SHALL wait for core_rd_data[8]=1.
REQ-011 CAP SHALL push core_rd_data[7:0] into the RX FIFO and decrement the remaining count.
REQ-012 CAP SHALL stall (no push, no decrement) while the RX FIFO is full.
REQ-013 In DESEL, SHALL drive one cycle of core_write=1, core_instr=01, core_wr_data=all ones; on the next cycle done SHALL pulse for one cycle and the FSM SHALL return to IDLE.
REQ-014 For cmd_len=0, SHALL go from IDLE straight to a one-cycle done pulse with no core writes.
REQ-015 core_write SHALL be high only in CFG, SEL, START and DESEL; core_instr and core_wr_data SHALL be 0 in all other states.
REQ-016 busy SHALL be 1 in every state except IDLE.
REQ-017 TX FIFO: tx_ready = not full; a byte is written when tx_valid and tx_ready are both high; writes SHALL be accepted in any state, including IDLE.
REQ-018 RX FIFO: rx_valid = not empty; rx_data SHALL show the head entry combinationally; a pop occurs when rx_valid and rx_ready are both high.
REQ-019 Each FIFO SHALL use (log2 DEPTH + 1)-bit read/write pointers that wrap modulo 2*DEPTH; full and empty SHALL be decoded from the MSB and the remaining bits.
REQ-020 A simultaneous push and pop SHALL be legal on a full or empty FIFO: a push to a full FIFO SHALL be blocked, and a pop from an empty FIFO SHALL be ignored.

Reset
REQ-021 While rst=0, regardless of clk: FSM=IDLE, both FIFOs empty, remaining count=0, latched command fields=0, core_write=0, core_instr=0, core_wr_data=0, busy=0, done=0, cmd_ready=1 (once rst=1), tx_ready=1, rx_valid=0.
REQ-022 Reset asserted mid-transaction SHALL abort immediately with no DESEL write; slave deselection is the responsibility of the core's own reset.

Verification
REQ-023 Single byte: cmd_len=1, ss=2'b10, dvsr=16'd4, mode 0, TX 0xA5, core model echoes 0x3C -> core writes in order: 11/0x00004, 01/0xFFFFFFFE, 10/0xA5, 01/0xFFFFFFFF; rx_data=0x3C; done pulses once.
REQ-024 Burst: cmd_len=4, TX 0x01-0x04 preloaded -> four instr=10 writes in order; four RX bytes in order; busy stays high throughout.
REQ-025 Back-pressure: cmd_len=10 with rx_ready=0 -> FSM holds in CAP after 8 pushes; releasing rx_ready completes all 10 bytes in order.
REQ-026 Starvation: cmd_len=2 with one TX byte supplied -> FSM parks in LOAD; a second byte supplied 50 cycles later -> transaction resumes and completes.
REQ-027 Edge cases: cmd_len=0 -> done pulse with no core_write; rst pulsed low while in WDONE -> all outputs reach reset values asynchronously and both FIFOs read empty.
